// File: rtl/uart_hex_pkg.sv
// uart_hex_pkg -- shared types and helpers for the hex-printing UART transmitter.
// Contents:
//   state_t        transmitter FSM state encoding
//   ASCII_CR/LF    line terminator characters appended after the 8 hex digits
//   LAST_CHAR_IDX  index of the final character (LF) in a printed word
//   nib2ascii()    4-bit value to uppercase ASCII hex digit
//   even_parity()  XOR of a data byte (even-parity bit value)
//   char_of()      character number idx (0..9) of the printed form of a word
package uart_hex_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam logic [3:0] LAST_CHAR_IDX = 4'd9;

    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        logic [7:0] asc;
        if (nib < 4'd10) begin
            asc = 8'h30 + {4'h0, nib};
        end else begin
            // 0x37 + n lands 10..15 on 'A'..'F'
            asc = 8'h37 + {4'h0, nib};
        end
        return asc;
    endfunction

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

    // Characters 0..7 are the nibbles MSB first, then CR, then LF.
    function automatic logic [7:0] char_of(input logic [31:0] word, input logic [3:0] idx);
        logic [31:0] shifted;
        logic [7:0]  chr;
        shifted = word << {idx[2:0], 2'b00};
        case (idx)
            4'd8:    chr = ASCII_CR;
            4'd9:    chr = ASCII_LF;
            default: chr = nib2ascii(shifted[31:28]);
        endcase
        return chr;
    endfunction

endpackage

// File: rtl/uart_hex_tx_baud.sv
// uart_baud_gen -- bit-period timer for the hex UART transmitter.
// Counts 0..DIVISOR-1 and wraps; bit_end is high during the last count of
// each bit period. clr restarts the period so bit cells line up with accept.
// DIVISOR must be at least 2.
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   clr      synchronous clear of the counter
//   bit_end  one-cycle tick in the final cycle of a bit period
module uart_baud_gen #(
    parameter int DIVISOR = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic bit_end
);

    localparam int               CNT_W    = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);

    logic [CNT_W-1:0] cnt_r;

    // Bit-period counter with synchronous clear and wrap at DIVISOR-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign bit_end = (cnt_r == CNT_LAST);

endmodule

// File: rtl/uart_hex_tx.sv
// uart_hex_tx -- prints a 32-bit debug word on a UART line as 8 uppercase
// hex characters (MSB nibble first) followed by CR LF.
// Build option: define UART_HEX_TX_PARITY_EN to append an even-parity bit
// after data bit 7 (8E1, 11-bit frames); undefined gives 8N1 framing.
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   word_in     word to print, sampled only on handshake
//   word_valid  word_in is valid
//   word_ready  high only while idle; accept = word_valid && word_ready
//   tx          UART serial line, idle high (registered)
//   busy        high from the cycle after accept through the done cycle
//   done        one-cycle pulse after the final LF stop bit
module uart_hex_tx
    import uart_hex_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int DIVISOR = CLK_HZ / BAUD;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] shadow_r;
    logic [3:0]  char_idx_r;
    logic [3:0]  char_idx_nxt_s;
    logic [2:0]  bit_idx_r;
    logic [2:0]  bit_idx_nxt_s;
    logic        accept_s;
    logic        bit_end_s;
    logic [7:0]  char_s;
    logic        tx_nxt_s;

    assign accept_s = word_valid && word_ready;

    uart_baud_gen #(
        .DIVISOR (DIVISOR)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept_s),
        .bit_end (bit_end_s)
    );

    // State, character/bit indices and the captured word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            char_idx_r <= 4'd0;
            bit_idx_r  <= 3'd0;
            shadow_r   <= 32'h0000_0000;
        end else begin
            state_r    <= state_nxt_s;
            char_idx_r <= char_idx_nxt_s;
            bit_idx_r  <= bit_idx_nxt_s;
            if (accept_s) begin
                shadow_r <= word_in;
            end else begin
                shadow_r <= shadow_r;
            end
        end
    end

    // Next-state and index sequencing; every bit cell ends on bit_end.
    always_comb begin
        state_nxt_s    = state_r;
        char_idx_nxt_s = char_idx_r;
        bit_idx_nxt_s  = bit_idx_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s    = ST_START;
                    char_idx_nxt_s = 4'd0;
                    bit_idx_nxt_s  = 3'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_nxt_s   = ST_DATA;
                    bit_idx_nxt_s = 3'd0;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    if (bit_idx_r == 3'd7) begin
`ifdef UART_HEX_TX_PARITY_EN
                        state_nxt_s = ST_PARITY;
`else
                        state_nxt_s = ST_STOP;
`endif
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
`ifdef UART_HEX_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end_s) begin
                    if (char_idx_r < LAST_CHAR_IDX) begin
                        // next start bit follows the stop bit with no idle gap
                        char_idx_nxt_s = char_idx_r + 4'd1;
                        state_nxt_s    = ST_START;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Line level for the upcoming cycle, derived from the next state so the
    // registered tx changes on the same edge as the state.
    always_comb begin
        char_s   = char_of(shadow_r, char_idx_nxt_s);
        tx_nxt_s = 1'b1;
        case (state_nxt_s)
            ST_START:  tx_nxt_s = 1'b0;
            ST_DATA:   tx_nxt_s = char_s[bit_idx_nxt_s];
            ST_PARITY: tx_nxt_s = even_parity(char_s);
            ST_STOP:   tx_nxt_s = 1'b1;
            default:   tx_nxt_s = 1'b1;
        endcase
    end

    // Registered outputs; reset drives the line idle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            word_ready <= 1'b1;
        end else begin
            tx         <= tx_nxt_s;
            busy       <= (state_nxt_s != ST_IDLE);
            done       <= (state_nxt_s == ST_DONE);
            word_ready <= (state_nxt_s == ST_IDLE);
        end
    end

endmodule

// File: doc/uart_hex_tx.md
Name: uart_hex_tx

Overview:
- Downstream consumer of the board-level debug display path.
- Takes a 32-bit debug word (PC, register, memory data, ALU address) through a valid/ready handshake.
- Transmits the word over a UART line as 8 uppercase ASCII hex characters, MSB nibble first, followed by CR LF.
- Contains its own baud timing, character sequencer and bit serializer. It replaces the fixed-byte, always-writing transmitter on the board.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- BAUD, 115200, line rate.
- DIVISOR (localparam), CLK_HZ/BAUD with integer truncation, clocks per bit (868 at defaults). Must be ≥ 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- word_in  input  32  word to print; sampled only on handshake.
- word_valid  input  1  word_in is valid.
- word_ready  output  1  high only in IDLE; the block accepts when word_valid && word_ready at a clk rising edge.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high from the cycle after accept until done.
- done  output  1  one-cycle pulse after the final LF stop bit completes.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, tx=1, busy=0, done=0, word_ready=1.
  - Baud counter, char index and bit index are all 0.
  - Reset mid-frame forces tx=1 immediately; the partial frame is abandoned.
- Accept: at the edge where word_valid && word_ready, latch word_in into the shadow register, set char_idx=0 and go to START. word_in is ignored thereafter.
- Character sequence, char_idx 0..9:
  - idx 0..7: nibble = word[31-4*idx -: 4].
  - ASCII = 0x30+n for n=0..9; 0x41+(n-10) for n=10..15.
  - idx 8 = 0x0D; idx 9 = 0x0A.
- Frame: start bit (0), 8 data bits LSB first, [parity bit, see Optional Feature], stop bit (1). Each bit is held exactly DIVISOR cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
  - IDLE → START on accept.
  - START → DATA after DIVISOR cycles.
  - DATA: bit_idx 0..7; after bit 7 → PARITY if enabled, else STOP.
  - PARITY → STOP after DIVISOR cycles.
  - STOP: after DIVISOR cycles, if char_idx<9 then char_idx++ and → START; else → DONE.
  - DONE: done=1 for exactly one cycle, → IDLE.
- tx is registered. The first start-bit cycle is the cycle after the accept edge. Consecutive characters are back-to-back, with no extra idle between a stop bit and the next start bit.
- Per-word timing: 10 chars × 10 bits × DIVISOR cycles (11 bits with parity). done is asserted the cycle after the last stop-bit cycle.
- Minimum gap: word_ready returns to 1 the cycle after done, so the next accept can occur at that edge.
- word_valid asserted while busy has no effect and is not queued.
- Baud counter: counts 0..DIVISOR-1 and wraps; it is cleared on accept so bit timing is phase-aligned to the accept.

Optional Feature:
- Macro UART_HEX_TX_PARITY_EN.
- Defined: a PARITY state inserts an even-parity bit (XOR of the 8 data bits) between data bit 7 and the stop bit. Frame is 11 bits.
- Undefined: no PARITY state, 8N1 framing, 10-bit frames.

Decomposition:
- Package uart_hex_pkg:
  - state enum type;
  - constants ASCII_CR=8'h0D, ASCII_LF=8'h0A;
  - function nib2ascii(logic[3:0]) returning logic[7:0].
- Sub-module uart_baud_gen (parameter DIVISOR): provides the counter and a one-cycle bit_end tick, with a synchronous clear input.
- Sequencer and serializer stay in uart_hex_tx.

Test Plan (CLK_HZ=16, BAUD=1 so DIVISOR=16 unless noted):
- Reset, no valid for 100 cycles → tx=1, word_ready=1, busy=0, done=0 throughout.
- Send 0xDEADBEEF → decoded bytes 0x44,0x45,0x41,0x44,0x42,0x45,0x45,0x46,0x0D,0x0A. done pulses exactly 1600 cycles after the first start-bit cycle; busy is low the cycle after done.
- Send 0x000000A5, then hold word_valid with 0x12345678 during transmission → only "000000A5\r\n" is sent. The second word is accepted the cycle after done and is sent as "12345678\r\n".
- Assert rst_n=0 mid-data-bit of the 3rd character → tx=1 in the same cycle (asynchronous), busy=0. After release, a new word 0x0 prints "00000000\r\n" correctly.
- With UART_HEX_TX_PARITY_EN, send 0x0000000E ('E'=0x45) → parity bit of the 8th character is 1; parity bit of '0' (0x30) is 0. done fires 1760 cycles after the first start bit.
- Defaults (DIVISOR=868), send 0x0 → each bit cell measures 868 cycles; start-bit falling edge occurs one cycle after accept.
